// File: rtl/rgbw_pwm_gen.sv
// Four-channel RGBW PWM generator. Counts rising edges of the slow prescaled clock and
// swaps in double-buffered duty values only at period boundaries, so duty changes never glitch.

module rgbw_pwm_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                commit,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [PWM_BITS-1:0] cnt,
  output logic                pwm
);
  logic [PWM_BITS-1:0] pending;
  logic [PWM_BITS-1:0] active;

  // On a load/commit collision the old pending value is committed and the new one captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      active  <= '0;
      pwm     <= 1'b0;
    end else begin
      if (load)   pending <= duty;
      if (commit) active  <= pending;
      pwm <= (cnt < active);
    end
  end
endmodule

module rgbw_pwm_gen #(
  parameter int PWM_BITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clkPresc,
  input  logic [PWM_BITS-1:0] dutyR,
  input  logic [PWM_BITS-1:0] dutyG,
  input  logic [PWM_BITS-1:0] dutyB,
  input  logic [PWM_BITS-1:0] dutyW,
  input  logic                dutyLoad,
  output logic                dutyAck,
  output logic                pwmR,
  output logic                pwmG,
  output logic                pwmB,
  output logic                pwmW,
  output logic                periodStart
);
  localparam int NUM_LANES = 4;
  localparam logic [PWM_BITS-1:0] CNT_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [0:0] EMPTY   = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   tick;
  logic                   wrap;
  logic                   commit;
  logic [PWM_BITS-1:0]    cnt;
  logic [0:0]             state;
  logic [1:0]             start_pipe;
  logic                   ack;

  logic [NUM_LANES-1:0][PWM_BITS-1:0] duty_in;
  logic [NUM_LANES-1:0]               pwm_vec;

  assign duty_in = {dutyW, dutyB, dutyG, dutyR};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], clkPresc};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign tick   = sync[SYNC_STAGES-1] & ~prev;
  assign wrap   = tick && (cnt == CNT_MAX);
  assign commit = wrap && (state == PENDING);

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)         state <= EMPTY;
    else if (dutyLoad) state <= PENDING;
    else if (commit)   state <= EMPTY;
  end

  // start_pipe[1] lines up with the first pwm sample of cnt = 0; ack lands one clk earlier.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_pipe <= '0;
      ack        <= 1'b0;
    end else begin
      start_pipe <= {start_pipe[0], wrap};
      ack        <= commit;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rgbw_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load   (dutyLoad),
      .commit (commit),
      .duty   (duty_in[i]),
      .cnt    (cnt),
      .pwm    (pwm_vec[i])
    );
  end

  assign {pwmW, pwmB, pwmG, pwmR} = pwm_vec;
  assign periodStart = start_pipe[1];
  assign dutyAck     = ack;
endmodule

// File: tb/tb_rgbw_pwm_gen.sv
// Scoreboard bench for rgbw_pwm_gen: per-period expected high-times pushed at stimulus,
// popped and compared against measured windows between periodStart pulses.

module tb_rgbw_pwm_gen;
  logic       clk = 1'b0;
  logic       reset;
  logic       clkPresc;
  logic [7:0] dutyR, dutyG, dutyB, dutyW;
  logic       dutyLoad;
  logic       dutyAck, pwmR, pwmG, pwmB, pwmW, periodStart;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   presc_half = 2;
  bit   presc_en = 1'b0;
  logic presc_manual = 1'b0;

  typedef struct {
    int r, g, b, w, len, acks;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Prescaled clock source; acts 1 ns after each negedge so test-side changes apply deterministically.
  initial begin
    int   ph;
    logic lvl;
    ph = 0;
    lvl = 1'b0;
    clkPresc = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (presc_en) begin
        ph++;
        if (ph >= presc_half) begin
          ph = 0;
          lvl = ~lvl;
        end
      end else begin
        ph = 0;
        lvl = presc_manual;
      end
      clkPresc = lvl;
    end
  end

  rgbw_pwm_gen #(.PWM_BITS(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .clkPresc    (clkPresc),
    .dutyR       (dutyR),
    .dutyG       (dutyG),
    .dutyB       (dutyB),
    .dutyW       (dutyW),
    .dutyLoad    (dutyLoad),
    .dutyAck     (dutyAck),
    .pwmR        (pwmR),
    .pwmG        (pwmG),
    .pwmB        (pwmB),
    .pwmW        (pwmW),
    .periodStart (periodStart)
  );

  task automatic set_duty(input logic [7:0] r, g, b, w);
    dutyR = r; dutyG = g; dutyB = b; dutyW = w;
  endtask

  task automatic wait_ps(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (periodStart) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Entered on a negedge where periodStart is high; returns on the next such negedge.
  // Loads (all four channels = v) are driven at window index la0/la1/la2.
  task automatic measure(input int la0, la1, la2, input logic [7:0] v0, v1, v2, output exp_t m);
    m = '{default: 0};
    for (int i = 0; i < 6000; i++) begin
      m.len++;
      if (pwmR) m.r++;
      if (pwmG) m.g++;
      if (pwmB) m.b++;
      if (pwmW) m.w++;
      if (dutyAck) m.acks++;
      dutyLoad = 1'b0;
      if (i == la0) begin dutyLoad = 1'b1; set_duty(v0, v0, v0, v0); end
      if (i == la1) begin dutyLoad = 1'b1; set_duty(v1, v1, v1, v1); end
      if (i == la2) begin dutyLoad = 1'b1; set_duty(v2, v2, v2, v2); end
      @(negedge clk);
      if (periodStart) break;
    end
    dutyLoad = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    dutyLoad = 1'b0;
    set_duty(8'd0, 8'd0, 8'd0, 8'd0);
    presc_half = 1;
    presc_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({pwmR, pwmG, pwmB, pwmW, dutyAck, periodStart} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b want 000000", {pwmR, pwmG, pwmB, pwmW, dutyAck, periodStart});
      end
    end
    presc_en = 1'b0;
    presc_manual = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pwmR, pwmG, pwmB, pwmW, dutyAck, periodStart} !== 6'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b want 000000", {pwmR, pwmG, pwmB, pwmW, dutyAck, periodStart});
    end
  endtask

  task automatic test_first_load;
    exp_t m, e;
    int   ps_seen;
    bit   got_ack;
    set_duty(8'd1, 8'd2, 8'd3, 8'd0);
    dutyLoad = 1'b1;
    presc_half = 2;
    presc_en = 1'b1;
    @(negedge clk);
    dutyLoad = 1'b0;
    sb.push_back('{r: 4, g: 8, b: 12, w: 0, len: 1020, acks: 0});
    ps_seen = 0;
    got_ack = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (dutyAck) begin got_ack = 1'b1; break; end
      if (periodStart) ps_seen++;
    end
    n_checks++;
    if (got_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL first_ack: got %0d want 1 (timeout)", got_ack);
    end
    n_checks++;
    if (ps_seen !== 0) begin
      n_fail++;
      $display("FAIL no_start_before_wrap: got %0d periodStart pulses want 0", ps_seen);
    end
    @(negedge clk);
    n_checks++;
    if (periodStart !== 1'b1 || dutyAck !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_before_start: got ps=%b ack=%b want ps=1 ack=0", periodStart, dutyAck);
    end
    measure(-1, -1, -1, 8'd0, 8'd0, 8'd0, m);
    e = sb.pop_front();
    n_checks++;
    if (m.r !== e.r || m.g !== e.g || m.b !== e.b || m.w !== e.w || m.len !== e.len || m.acks !== e.acks) begin
      n_fail++;
      $display("FAIL first_period: got r%0d g%0d b%0d w%0d len%0d ack%0d want r%0d g%0d b%0d w%0d len%0d ack%0d",
               m.r, m.g, m.b, m.w, m.len, m.acks, e.r, e.g, e.b, e.w, e.len, e.acks);
    end
  endtask

  // Active R=1, G=2: pwmR high only at cnt 0, pwmG high for cnt 0..1.
  task automatic test_tick_latency;
    presc_en = 1'b0;
    presc_manual = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (pwmR !== 1'b1 || pwmG !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_cnt0: got r=%b g=%b want r=1 g=1", pwmR, pwmG);
    end
    presc_manual = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (pwmR !== logic'(k < 4)) begin
        n_fail++;
        $display("FAIL tick_latency edge%0d: got pwmR=%b want %b", k, pwmR, logic'(k < 4));
      end
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (pwmG !== 1'b1) begin
      n_fail++;
      $display("FAIL single_tick_width: got pwmG=%b want 1", pwmG);
    end
    presc_manual = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (pwmG !== 1'b1) begin
      n_fail++;
      $display("FAIL falling_ignored: got pwmG=%b want 1", pwmG);
    end
    presc_manual = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pwmG !== 1'b1) begin
      n_fail++;
      $display("FAIL second_tick_early: got pwmG=%b want 1", pwmG);
    end
    @(negedge clk);
    n_checks++;
    if (pwmG !== 1'b0) begin
      n_fail++;
      $display("FAIL second_tick: got pwmG=%b want 0", pwmG);
    end
    presc_manual = 1'b0;
  endtask

  task automatic test_nominal;
    exp_t m, e;
    bit   ok;
    set_duty(8'd0, 8'd1, 8'd128, 8'd255);
    dutyLoad = 1'b1;
    presc_half = 10;
    presc_en = 1'b1;
    @(negedge clk);
    dutyLoad = 1'b0;
    repeat (2) sb.push_back('{r: 0, g: 20, b: 2560, w: 5100, len: 5100, acks: 0});
    wait_ps(12000, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_wrap: got timeout want periodStart");
    end
    for (int p = 0; p < 2; p++) begin
      measure(-1, -1, -1, 8'd0, 8'd0, 8'd0, m);
      e = sb.pop_front();
      n_checks++;
      if (m.r !== e.r || m.g !== e.g || m.b !== e.b || m.w !== e.w || m.len !== e.len || m.acks !== e.acks) begin
        n_fail++;
        $display("FAIL nominal p%0d: got r%0d g%0d b%0d w%0d len%0d ack%0d want r%0d g%0d b%0d w%0d len%0d ack%0d",
                 p, m.r, m.g, m.b, m.w, m.len, m.acks, e.r, e.g, e.b, e.w, e.len, e.acks);
      end
    end
  endtask

  task automatic test_glitch_free;
    exp_t m, e;
    presc_half = 2;
    measure(-1, -1, -1, 8'd0, 8'd0, 8'd0, m);  // settle onto the faster tick rate
    sb.push_back('{r: 0,   g: 4,   b: 512, w: 1020, len: 1020, acks: 1});
    sb.push_back('{r: 256, g: 256, b: 256, w: 256,  len: 1020, acks: 1});
    sb.push_back('{r: 800, g: 800, b: 800, w: 800,  len: 1020, acks: 0});
    for (int p = 0; p < 3; p++) begin
      case (p)
        0:       measure(10,  -1, -1, 8'd64,  8'd0, 8'd0, m);
        1:       measure(400, -1, -1, 8'd200, 8'd0, 8'd0, m);
        default: measure(-1,  -1, -1, 8'd0,   8'd0, 8'd0, m);
      endcase
      e = sb.pop_front();
      n_checks++;
      if (m.r !== e.r || m.g !== e.g || m.b !== e.b || m.w !== e.w || m.len !== e.len || m.acks !== e.acks) begin
        n_fail++;
        $display("FAIL glitch_free p%0d: got r%0d g%0d b%0d w%0d len%0d ack%0d want r%0d g%0d b%0d w%0d len%0d ack%0d",
                 p, m.r, m.g, m.b, m.w, m.len, m.acks, e.r, e.g, e.b, e.w, e.len, e.acks);
      end
    end
  endtask

  // Window index 1018 drives dutyLoad into the wrap edge.
  task automatic test_back_to_back;
    exp_t m, e;
    sb.push_back('{r: 800, g: 800, b: 800, w: 800, len: 1020, acks: 1});
    sb.push_back('{r: 120, g: 120, b: 120, w: 120, len: 1020, acks: 1});
    sb.push_back('{r: 120, g: 120, b: 120, w: 120, len: 1020, acks: 1});
    sb.push_back('{r: 160, g: 160, b: 160, w: 160, len: 1020, acks: 1});
    for (int p = 0; p < 4; p++) begin
      case (p)
        0:       measure(100, 300,  600, 8'd10,  8'd20, 8'd30, m);
        1:       measure(100, 1018, -1,  8'd30,  8'd40, 8'd0,  m);
        2:       measure(-1,  -1,   -1,  8'd0,   8'd0,  8'd0,  m);
        default: measure(500, -1,   -1,  8'd255, 8'd0,  8'd0,  m);
      endcase
      e = sb.pop_front();
      n_checks++;
      if (m.r !== e.r || m.g !== e.g || m.b !== e.b || m.w !== e.w || m.len !== e.len || m.acks !== e.acks) begin
        n_fail++;
        $display("FAIL back_to_back p%0d: got r%0d g%0d b%0d w%0d len%0d ack%0d want r%0d g%0d b%0d w%0d len%0d ack%0d",
                 p, m.r, m.g, m.b, m.w, m.len, m.acks, e.r, e.g, e.b, e.w, e.len, e.acks);
      end
    end
  endtask

  task automatic test_reset_mid;
    int highs, acks, starts;
    repeat (400) @(negedge clk);
    n_checks++;
    if ({pwmR, pwmG, pwmB, pwmW} !== 4'hf) begin
      n_fail++;
      $display("FAIL pre_reset_high: got %b want 1111", {pwmR, pwmG, pwmB, pwmW});
    end
    set_duty(8'd50, 8'd50, 8'd50, 8'd50);
    dutyLoad = 1'b1;
    @(negedge clk);
    dutyLoad = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({pwmR, pwmG, pwmB, pwmW, dutyAck, periodStart} !== 6'b0) begin
        n_fail++;
        $display("FAIL mid_reset_outputs: got %b want 000000", {pwmR, pwmG, pwmB, pwmW, dutyAck, periodStart});
      end
    end
    reset = 1'b0;
    highs = 0; acks = 0; starts = 0;
    repeat (2500) begin
      @(negedge clk);
      if (pwmR || pwmG || pwmB || pwmW) highs++;
      if (dutyAck) acks++;
      if (periodStart) starts++;
    end
    n_checks++;
    if (highs !== 0) begin
      n_fail++;
      $display("FAIL pending_discarded_pwm: got %0d high cycles want 0", highs);
    end
    n_checks++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL pending_discarded_ack: got %0d acks want 0", acks);
    end
    n_checks++;
    if (starts !== 2) begin
      n_fail++;
      $display("FAIL restart_periods: got %0d periodStart pulses want 2", starts);
    end
  endtask

  initial begin
    test_reset;
    test_first_load;
    test_tick_latency;
    test_nominal;
    test_glitch_free;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion want finish before 900000 ns");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rgbw_pwm_gen.md
Name: rgbw_pwm_gen

Overview:
- Consumer end of the PWM prescaler output: takes the slow prescaled square wave `clkPresc` and uses its rising edges as count ticks.
- Advances an 8-bit PWM period counter on each tick and drives four PWM outputs (R, G, B, W).
- Duty values are double-buffered behind a load/acknowledge handshake, so updates take effect only at a period boundary and never cause glitches.
- Sits between the colour/duty register logic and the LED driver pins, all in the single `clk` domain.

Parameters:
- PWM_BITS, 8, width of the period counter and of each duty value.
- SYNC_STAGES, 2, number of flops that synchronise `clkPresc` before edge detection (minimum 2).

Ports:
- clk  input  1  system clock; every register runs on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clkPresc  input  1  prescaled square wave from the PWM clock divider; treated as an asynchronous, slow input.
- dutyR  input  PWM_BITS  requested red duty.
- dutyG  input  PWM_BITS  requested green duty.
- dutyB  input  PWM_BITS  requested blue duty.
- dutyW  input  PWM_BITS  requested white duty.
- dutyLoad  input  1  one-cycle strobe; captures all four duty inputs into the pending buffer.
- dutyAck  output  1  one-cycle pulse when the pending duties become active.
- pwmR  output  1  red PWM output, registered.
- pwmG  output  1  green PWM output, registered.
- pwmB  output  1  blue PWM output, registered.
- pwmW  output  1  white PWM output, registered.
- periodStart  output  1  one-cycle pulse marking the first cycle of each PWM period on the outputs.

Behaviour:
- Reset (synchronous, active-high):
  - Sync chain, edge-detect flop, cnt, active duties, pending duties and the pending flag all clear to 0.
  - All outputs are 0 on the cycle after the reset edge.
  - Reset asserted mid-period aborts the period immediately; any pending load is discarded.
- Tick generation:
  - `clkPresc` passes through SYNC_STAGES flops, then one more "prev" flop.
  - tick = last sync stage AND NOT prev, i.e. exactly one clk wide per `clkPresc` rising edge.
  - Falling edges are ignored.
  - Latency: cnt changes on clk edge SYNC_STAGES+1 after the first edge that samples `clkPresc` high.
- Counter:
  - cnt runs 0..(2^PWM_BITS − 2), giving 255 ticks per period at the default width.
  - On a tick with cnt = 254, cnt wraps to 0; otherwise cnt increments by 1.
  - cnt holds between ticks.
- PWM compare, registered every clk: pwmX <= (cnt < activeX).
  - Duty 0 → output constantly low.
  - Duty 255 → output constantly high.
  - Duty N → high for N of every 255 ticks.
  - Outputs lag cnt by one clk.
- Pending-flag FSM, states EMPTY and PENDING:
  - EMPTY + dutyLoad → capture all four inputs into pending, go to PENDING.
  - PENDING + dutyLoad → overwrite pending (last load wins), stay PENDING.
  - PENDING + wrap tick with no simultaneous dutyLoad → copy pending to active, pulse dutyAck, go to EMPTY.
  - PENDING + wrap tick + dutyLoad in the same cycle → the old pending value goes active and dutyAck pulses; the new inputs are captured as pending and state stays PENDING.
  - EMPTY + wrap tick → active unchanged, no dutyAck.
- Update timing:
  - An active-duty change is visible on pwmX starting with the cnt = 0 cycle of the next period.
  - No partial-period duty is ever produced.
- periodStart:
  - Registered; high for exactly the one clk in which the pwm outputs first reflect cnt = 0.
  - Not asserted after reset until the first wrap.
- dutyAck rises on the same edge that active updates. It is therefore one clk ahead of periodStart.

Test Plan:
- Reset behaviour: hold reset 3 cycles while `clkPresc` toggles → all outputs 0; cnt stays 0; no tick is counted while reset is high.
- Tick latency and width: toggle `clkPresc` every 10 clk → tick is one clk wide; cnt increments once per 20 clk; cnt changes 3 edges after the first sampled high level; falling edges do not count.
- Nominal duty: load R=0, G=1, B=128, W=255, then run two full periods (5100 clk) → in the second period pwmR always 0, pwmG high 20 clk, pwmB high 2560 clk, pwmW always 1.
- Glitch-free update: mid-period with R=64 active, load R=200 → pwmR keeps the 64-tick width for the rest of that period; dutyAck pulses once at the wrap; the next period shows 200 ticks.
- Last-wins and collision: issue three loads (10, 20, 30) in one period → the next period uses 30 with a single dutyAck. Issue dutyLoad=40 on the exact wrap cycle while 30 is pending → 30 goes active, 40 goes active one period later, with two dutyAck pulses in total.
- Reset mid-operation: assert reset with a load pending and cnt = 100 → all outputs 0 and the pending load lost. After release with no new load, pwm outputs stay 0 for all duties.
